// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and range helper for the raster generator.
package vga_pkg;
  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // True when c lies in the half-open window [lo, lo+n).
  function automatic logic in_span(input coord_t c, input int lo, input int n);
    return (int'(c) >= lo) && (int'(c) < lo + n);
  endfunction
endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-Clk pix_en strobe per pixel and a registered VGA_CLK
// that falls when the divider wraps and rises at the half-period point.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic pix_en,
  output logic VGA_CLK
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, vclk_q;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
  end

  // Strobe and clock are decoded from the next divider value so they line up
  // with the counter state that the top module registers on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      vclk_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= (div_d == LAST);
      vclk_q   <= (div_d >= HALF);
    end
  end

  assign pix_en  = pix_en_q;
  assign VGA_CLK = vclk_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters and registered sync/blank/coordinate outputs.
// Define VGA_PREFETCH_EN to present the coordinates of the next pixel on ReadX/ReadY.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic   Clk,
  input  logic   Reset_n,
  output logic   VGA_CLK,
  output logic   VGA_HS,
  output logic   VGA_VS,
  output logic   VGA_BLANK_N,
  output logic   VGA_SYNC_N,
  output coord_t ReadX,
  output coord_t ReadY,
  output logic   pix_en,
  output logic   frame_start
);
  localparam int     HT     = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int     VT     = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
`ifdef VGA_PREFETCH_EN
  localparam coord_t RESET_X = coord_t'(1);
`else
  localparam coord_t RESET_X = coord_t'(0);
`endif

  coord_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  coord_t readx_q, readx_d, ready_q, ready_d;
  logic   hs_q, vs_q, blank_q, fs_q, fs_d;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .pix_en  (pix_en),
    .VGA_CLK (VGA_CLK)
  );

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fs_d   = 1'b0;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        fs_d   = (vcnt_q == V_LAST);
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
`ifdef VGA_PREFETCH_EN
    // Look one pixel ahead so the framebuffer read lands in time for the DAC.
    readx_d = (hcnt_d == H_LAST) ? '0 : hcnt_d + 1'b1;
    if (hcnt_d != H_LAST)      ready_d = vcnt_d;
    else if (vcnt_d == V_LAST) ready_d = '0;
    else                       ready_d = vcnt_d + 1'b1;
`else
    readx_d = hcnt_d;
    ready_d = vcnt_d;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      readx_q <= RESET_X;
      ready_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      readx_q <= readx_d;
      ready_q <= ready_d;
      hs_q    <= !in_span(hcnt_d, H_VISIBLE + H_FP, H_SYNC);
      vs_q    <= !in_span(vcnt_d, V_VISIBLE + V_FP, V_SYNC);
      blank_q <= (int'(hcnt_d) < H_VISIBLE) && (int'(vcnt_d) < V_VISIBLE);
      fs_q    <= fs_d;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign ReadX       = readx_q;
  assign ReadY       = ready_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing instance,
// both checked every cycle against an arithmetic model of edges elapsed since reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int cd; int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb;
  } tim_t;

  typedef struct packed {
    logic       vclk; logic pix; logic hs; logic vs; logic blank; logic sync_n; logic fs;
    logic [9:0] x;
    logic [9:0] y;
  } vo_t;

  typedef struct {
    int k; int h; int v; bit hs; bit bl; bit vclk; bit pix;
  } vec_t;

`ifdef VGA_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  localparam tim_t TA = '{cd:2, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
  localparam tim_t TB = '{cd:4, hv:8, hf:2, hs:3, hb:3, vv:6, vf:2, vs:2, vb:2};

  logic   Clk = 1'b0;
  logic   rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic   a_vclk, a_hs, a_vs, a_bl, a_sync, a_pix, a_fs;
  logic   b_vclk, b_hs, b_vs, b_bl, b_sync, b_pix, b_fs;
  coord_t a_x, a_y, b_x, b_y;
  vo_t    oa, ob;

  int tests = 0, fails = 0;
  int ka = 0, kb = 0;
  int hs_low = 0, bl_hi = 0;
  int line_k0 = -1, line_k1 = -1, fs_k0 = -1, fs_k1 = -1;
  logic [9:0] prev_ax = '0;

  always #5 Clk = ~Clk;

  vga_timing_gen ua (
    .Clk(Clk), .Reset_n(rst_a_n), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sync), .ReadX(a_x), .ReadY(a_y),
    .pix_en(a_pix), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) ub (
    .Clk(Clk), .Reset_n(rst_b_n), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sync), .ReadX(b_x), .ReadY(b_y),
    .pix_en(b_pix), .frame_start(b_fs)
  );

  assign oa = {a_vclk, a_pix, a_hs, a_vs, a_bl, a_sync, a_fs, a_x, a_y};
  assign ob = {b_vclk, b_pix, b_hs, b_vs, b_bl, b_sync, b_fs, b_x, b_y};

  // Expected outputs after k edges since reset release (k = 0 means in reset).
  function automatic vo_t model(input int k, input tim_t t);
    vo_t o;
    int ht, vt, p, ph, h, v;
    ht = t.hv + t.hf + t.hs + t.hb;
    vt = t.vv + t.vf + t.vs + t.vb;
    p  = k / t.cd;
    ph = k % t.cd;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.vclk   = (ph >= t.cd / 2);
    o.pix    = (ph == t.cd - 1);
    o.hs     = !(h >= t.hv + t.hf && h < t.hv + t.hf + t.hs);
    o.vs     = !(v >= t.vv + t.vf && v < t.vv + t.vf + t.vs);
    o.blank  = (h < t.hv) && (v < t.vv);
    o.sync_n = 1'b0;
    o.fs     = (ph == 0) && (p > 0) && (p % (ht * vt) == 0);
    if (PF) begin
      o.x = 10'((h + 1) % ht);
      o.y = 10'((h == ht - 1) ? (v + 1) % vt : v);
    end else begin
      o.x = 10'(h);
      o.y = 10'(v);
    end
    if (k == 0) begin
      o.vclk = 1'b0; o.pix = 1'b0; o.hs = 1'b1; o.vs = 1'b1;
      o.blank = 1'b0; o.fs = 1'b0; o.x = PF ? 10'd1 : 10'd0; o.y = '0;
    end
    return o;
  endfunction

  task automatic check_vo(input string name, input int k, input vo_t got, input vo_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got vclk,pix,hs,vs,bl,syn,fs=%b x=%0d y=%0d required %b x=%0d y=%0d",
               name, k, got[26:20], got.x, got.y, exp[26:20], exp.x, exp.y);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    ka = rst_a_n ? ka + 1 : 0;
    kb = rst_b_n ? kb + 1 : 0;
    @(negedge Clk);
    check_vo("model_a", ka, oa, model(ka, TA));
    check_vo("model_b", kb, ob, model(kb, TB));
    if (ka >= 1 && ka <= 1600) begin
      if (!a_hs) hs_low++;
      if (a_bl)  bl_hi++;
    end
    if (ka > 0 && oa.x == 0 && prev_ax != 0) begin
      if (line_k0 < 0)      line_k0 = ka;
      else if (line_k1 < 0) line_k1 = ka;
    end
    prev_ax = oa.x;
    if (b_fs && fs_k1 < 0) begin
      if (fs_k0 < 0) fs_k0 = kb;
      else           fs_k1 = kb;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    vo_t  rexp, e;
    int   n, hold;
    tbl[0]  = '{k:1,    h:0,   v:0, hs:1, bl:1, vclk:1, pix:1};
    tbl[1]  = '{k:2,    h:1,   v:0, hs:1, bl:1, vclk:0, pix:0};
    tbl[2]  = '{k:1279, h:639, v:0, hs:1, bl:1, vclk:1, pix:1};
    tbl[3]  = '{k:1280, h:640, v:0, hs:1, bl:0, vclk:0, pix:0};
    tbl[4]  = '{k:1311, h:655, v:0, hs:1, bl:0, vclk:1, pix:1};
    tbl[5]  = '{k:1312, h:656, v:0, hs:0, bl:0, vclk:0, pix:0};
    tbl[6]  = '{k:1503, h:751, v:0, hs:0, bl:0, vclk:1, pix:1};
    tbl[7]  = '{k:1504, h:752, v:0, hs:1, bl:0, vclk:0, pix:0};
    tbl[8]  = '{k:1599, h:799, v:0, hs:1, bl:0, vclk:1, pix:1};
    tbl[9]  = '{k:1600, h:0,   v:1, hs:1, bl:1, vclk:0, pix:0};
    tbl[10] = '{k:3200, h:0,   v:2, hs:1, bl:1, vclk:0, pix:0};

    // Cold reset on both instances.
    for (int i = 0; i < 5; i++) step();
    rexp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (PF ? 10'd1 : 10'd0), 10'd0};
    check_vo("reset_a", ka, oa, rexp);
    check_vo("reset_b", kb, ob, rexp);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Hand-computed points along the first lines of the default raster.
    for (int i = 0; i < 11; i++) begin
      n = 0;
      while (ka < tbl[i].k && n < 5000) begin step(); n++; end
      e.vclk = tbl[i].vclk; e.pix = tbl[i].pix; e.hs = tbl[i].hs; e.vs = 1'b1;
      e.blank = tbl[i].bl; e.sync_n = 1'b0; e.fs = 1'b0;
      if (PF) begin
        e.x = 10'((tbl[i].h == 799) ? 0 : tbl[i].h + 1);
        e.y = 10'((tbl[i].h == 799) ? tbl[i].v + 1 : tbl[i].v);
      end else begin
        e.x = 10'(tbl[i].h);
        e.y = 10'(tbl[i].v);
      end
      check_vo("tbl", ka, oa, e);
    end

    // Mid-frame reset of the small instance at h=5, v=4.
    n = 0;
    while (!(((kb / TB.cd) % 16 == 5) && ((kb / TB.cd / 16) % 12 == 4)) && n < 2000) begin
      step(); n++;
    end
    check_int("midframe_reach", n < 2000 ? 1 : 0, 1);
    rst_b_n = 1'b0;
    step();
    check_int("mid_rst_x", int'(b_x), PF ? 1 : 0);
    check_int("mid_rst_y", int'(b_y), 0);
    check_int("mid_rst_hs", int'(b_hs), 1);
    check_int("mid_rst_vs", int'(b_vs), 1);
    check_int("mid_rst_blank", int'(b_bl), 0);
    rst_b_n = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // Random reset pulses on the small instance.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!rst_b_n) begin
        if (hold > 0) hold--;
        else          rst_b_n = 1'b1;
      end else if ($urandom_range(999) == 0) begin
        rst_b_n = 1'b0;
        hold    = int'($urandom_range(2));
      end
      step();
    end

    check_int("hs_low_clks_line0", hs_low, 192);
    check_int("blank_hi_clks_line0", bl_hi, 1280);
    check_int("line_period", line_k1 - line_k0, 1600);
    check_int("first_frame_start_b", fs_k0, 768);
    check_int("frame_period_b", fs_k1 - fs_k0, 768);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
